// File: rtl/frame_conv3x3_engine.sv
// rtl/frame_conv3x3_engine.sv - streaming 3x3 neighbourhood filter over a frame held in RAM
module frame_conv3x3_engine #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int CH_W       = 4,
    parameter int AW         = 19,
    parameter int DST_OFFSET = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [AW-1:0]       rd_addr,
    input  logic [3*CH_W-1:0]   rd_data,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [3*CH_W-1:0]   wr_data
);
    localparam int PIX_W = 3 * CH_W;
    localparam int N     = IMG_W * IMG_H;
    localparam int PW    = $clog2(N + IMG_W + 2) + 1;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int LW    = CH_W + 7;
    localparam int VW    = CH_W + 6;

    localparam logic [AW-1:0] RD_LAST = AW'(N - 1);
    localparam logic [AW-1:0] DST     = AW'(DST_OFFSET);
    localparam logic [PW-1:0] P_FIRST = PW'(IMG_W + 1);
    localparam logic [PW-1:0] P_LAST  = PW'(N + IMG_W);
    localparam logic [PW-1:0] P_END   = PW'(N + IMG_W + 1);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [VW-1:0] VMAX    = VW'((1 << CH_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                rd_en_q, rd_en_d, rd_valid_q, rd_valid_d;
    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic                wr_en_q, wr_en_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d, o_q, o_d;
    logic [PIX_W-1:0]    wr_data_q, wr_data_d;
    logic [PW-1:0]       p_q, p_d;
    logic [XW-1:0]       x_q, x_d, ptr_q, ptr_d;
    logic [YW-1:0]       y_q, y_d;
    logic [1:0]          mode_q, mode_d;
    logic [3*PIX_W-1:0]  col0_q, col0_d, col1_q, col1_d, col_new;

    logic [PIX_W-1:0]    lb0_q [IMG_W];
    logic [PIX_W-1:0]    lb1_q [IMG_W];

    logic                push;
    logic [PIX_W-1:0]    push_data;
    logic [PIX_W-1:0]    win [9];
    logic [CH_W-1:0]     yv [9];
    logic [VW-1:0]       nsum, mult, v;
    logic [CH_W-1:0]     vc;
    logic [PIX_W-1:0]    result;

    function automatic logic [CH_W-1:0] luma(input logic [PIX_W-1:0] px);
        logic [LW-1:0] s;
        logic [LW-1:0] q;
        s = LW'(px[PIX_W-1 -: CH_W]) * LW'(30)
          + LW'(px[2*CH_W-1 -: CH_W]) * LW'(59)
          + LW'(px[CH_W-1:0]) * LW'(11);
        q = s / LW'(100);
        return q[CH_W-1:0];
    endfunction

    // Zeros stand in for positions past the end of the frame while the pipeline drains.
    assign push      = rd_valid_q || (state_q == S_FLUSH && p_q <= P_LAST);
    assign push_data = rd_valid_q ? rd_data : '0;
    assign col_new   = {lb1_q[ptr_q], lb0_q[ptr_q], push_data};

    // Window centre sits in col1; the incoming column completes the right edge.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win[r*3 + 0] = col0_q[(3-r)*PIX_W-1 -: PIX_W];
            win[r*3 + 1] = col1_q[(3-r)*PIX_W-1 -: PIX_W];
            win[r*3 + 2] = col_new[(3-r)*PIX_W-1 -: PIX_W];
        end
    end

    always_comb begin
        nsum = '0;
        for (int i = 0; i < 9; i++) begin
            yv[i] = luma(win[i]);
            if (i != 4 &&
                !((i % 3) == 0 && x_q == '0) && !((i % 3) == 2 && x_q == X_LAST) &&
                !((i / 3) == 0 && y_q == '0) && !((i / 3) == 2 && y_q == Y_LAST))
                nsum = nsum + VW'(yv[i]);
        end
        mult = (mode_q == 2'd2) ? VW'(yv[4]) * VW'(9) : VW'(yv[4]) * VW'(8);
        v    = mult - nsum;
        if (v[VW-1])
            vc = '0;
        else if (v > VMAX)
            vc = '1;
        else
            vc = v[CH_W-1:0];
        case (mode_q)
            2'd0:    result = win[4];
            2'd1:    result = {yv[4], yv[4], yv[4]};
            default: result = {vc, vc, vc};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_valid_d = rd_en_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        p_d        = p_q;
        o_d        = o_q;
        x_d        = x_q;
        y_d        = y_q;
        ptr_d      = ptr_q;
        col0_d     = col0_q;
        col1_d     = col1_q;
        mode_d     = mode_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d   = S_RUN;
                rd_en_d   = 1'b1;
                rd_addr_d = '0;
                mode_d    = mode;
                p_d       = '0;
                o_d       = '0;
                x_d       = '0;
                y_d       = '0;
                ptr_d     = '0;
            end
            S_RUN: begin
                rd_en_d   = 1'b1;
                rd_addr_d = rd_addr_q + AW'(1);
                if (rd_addr_q == RD_LAST) begin
                    rd_en_d   = 1'b0;
                    rd_addr_d = rd_addr_q;
                    state_d   = S_FLUSH;
                end
            end
            S_FLUSH: if (p_q == P_END) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (push) begin
            col0_d = col1_q;
            col1_d = col_new;
            ptr_d  = (ptr_q == X_LAST) ? '0 : ptr_q + XW'(1);
            p_d    = p_q + PW'(1);
            if (p_q >= P_FIRST) begin
                wr_en_d   = 1'b1;
                wr_addr_d = o_q + DST;
                wr_data_d = result;
                o_d       = o_q + AW'(1);
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            p_q        <= '0;
            o_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            ptr_q      <= '0;
            col0_q     <= '0;
            col1_q     <= '0;
            mode_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            p_q        <= p_d;
            o_q        <= o_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ptr_q      <= ptr_d;
            col0_q     <= col0_d;
            col1_q     <= col1_d;
            mode_q     <= mode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lb0_q[ptr_q] <= push_data;
            lb1_q[ptr_q] <= lb0_q[ptr_q];
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
endmodule

// File: tb/tb_frame_conv3x3_engine.sv
// tb/tb_frame_conv3x3_engine.sv - self-checking bench for frame_conv3x3_engine
module tb_frame_conv3x3_engine;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [1:0]    mode;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [11:0]   rd_data, wr_data;

    frame_conv3x3_engine #(.IMG_W(W), .IMG_H(H), .CH_W(4), .AW(AW), .DST_OFFSET(0)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    logic [11:0] ram   [0:15];
    logic [11:0] frame [0:15];
    logic [11:0] img   [0:15];
    logic [11:0] wlog  [0:15];
    logic        load_req = 1'b0;
    logic        rst_at_edge = 1'b0;
    logic        pass_active = 1'b0;
    logic [1:0]  pass_mode = 2'd0;
    int          cyc = 0;
    int          c0 = 0;
    int          wcount = 0;
    int          base = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
        if (rd_en) rd_data <= ram[rd_addr[3:0]];
        if (load_req) begin
            for (int k = 0; k < 16; k++) ram[k] <= frame[k];
        end else if (wr_en) begin
            ram[wr_addr[3:0]] <= wr_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int luma(input logic [11:0] p);
        logic [11:0] q;
        q = p;
        return (30 * int'(q[11:8]) + 59 * int'(q[7:4]) + 11 * int'(q[3:0])) / 100;
    endfunction

    // Reference: direct neighbourhood sum over the pre-pass image.
    function automatic logic [11:0] exp_pix(input int o);
        int x, y, yc, s, v;
        logic [3:0] c;
        x  = o % W;
        y  = o / W;
        yc = luma(img[o]);
        if (pass_mode == 2'd0) return img[o];
        c = 4'(yc);
        if (pass_mode == 2'd1) return {c, c, c};
        s = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
                    s += luma(img[(y + dy) * W + x + dx]);
        v = ((pass_mode == 2'd2) ? 9 : 8) * yc - s;
        if (v < 0) v = 0;
        if (v > 15) v = 15;
        c = 4'(v);
        return {c, c, c};
    endfunction

    initial begin
        int t;
        logic eb, ed, er, ew;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_at_edge) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_rd_en", rd_en, 0);
                chk("rst_wr_en", wr_en, 0);
                chk("rst_rd_addr", rd_addr, 0);
                chk("rst_wr_addr", wr_addr, 0);
                chk("rst_wr_data", wr_data, 0);
            end else begin
                t  = pass_active ? cyc - c0 : -1000;
                eb = (t >= 1 && t <= W + 4 + N);
                ed = (t == W + 4 + N);
                er = (t >= 1 && t <= N);
                ew = (t >= W + 4 && t < W + 4 + N);
                chk("busy", busy, eb);
                chk("done", done, ed);
                chk("rd_en", rd_en, er);
                if (er) chk("rd_addr", rd_addr, t - 1);
                chk("wr_en", wr_en, ew);
                if (ew) begin
                    chk("wr_addr", wr_addr, t - W - 4);
                    chk("wr_data", wr_data, exp_pix(t - W - 4));
                end
                if (wr_en && wr_addr < 16) begin
                    wlog[wr_addr[3:0]] = wr_data;
                    wcount++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic start_pass(input logic [1:0] m);
        for (int k = 0; k < 16; k++) img[k] = ram[k];
        mode        = m;
        start       = 1'b1;
        c0          = cyc;
        pass_mode   = m;
        base        = wcount;
        pass_active = 1'b1;
        tick();
        start = 1'b0;
        mode  = 2'($urandom);
    endtask

    task automatic finish_pass;
        repeat (W + N + 6) tick();
        chk("write_count", wcount - base, N);
    endtask

    task automatic run_pass(input logic [1:0] m);
        start_pass(m);
        finish_pass();
    endtask

    task automatic fill(input logic [11:0] p);
        for (int k = 0; k < 16; k++) frame[k] = p;
        load();
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        tick();
        repeat (6) begin
            start = 1'($urandom);
            mode  = 2'($urandom);
            tick();
        end
        start = 1'b0;
        rst   = 1'b1;
        repeat (20) tick();

        for (int k = 0; k < 16; k++) frame[k] = 12'(k * 12'h111);
        load();
        run_pass(2'd0);
        chk("pass_k0", wlog[0], 12'h000);
        chk("pass_k7", wlog[7], 12'h777);
        chk("pass_k11", wlog[11], 12'hBBB);

        fill(12'hF00);
        run_pass(2'd1);
        chk("gray_f00", wlog[6], 12'h444);
        chk("model_gray_f00", exp_pix(6), 12'h444);
        fill(12'h0F0);
        run_pass(2'd1);
        chk("gray_0f0", wlog[11], 12'h888);

        fill(12'h777);
        run_pass(2'd2);
        chk("sharp_i5", wlog[5], 12'h777);
        chk("sharp_i6", wlog[6], 12'h777);
        chk("sharp_corner", wlog[0], 12'hFFF);
        chk("sharp_border", wlog[1], 12'hFFF);
        chk("model_sharp_i5", exp_pix(5), 12'h777);
        fill(12'h777);
        run_pass(2'd3);
        chk("edge_interior", wlog[6], 12'h000);
        chk("edge_corner", wlog[11], 12'hFFF);
        chk("model_edge_corner", exp_pix(0), 12'hFFF);

        for (int k = 0; k < 16; k++) frame[k] = 12'h000;
        frame[5] = 12'hFFF;
        load();
        run_pass(2'd3);
        chk("bright_centre", wlog[5], 12'hFFF);
        chk("model_bright", exp_pix(5), 12'hFFF);
        foreach (wlog[k]) if (k < N && k != 5 && k != 3 && k != 7 && k != 11)
            chk("bright_nb", wlog[k], 12'h000);
        chk("bright_nowrap", wlog[3], 12'h000);

        for (int k = 0; k < 16; k++) frame[k] = 12'($urandom);
        load();
        start_pass(2'd2);
        repeat (4) tick();
        start = 1'b1;
        mode  = 2'd0;
        tick();
        start = 1'b0;
        finish_pass();

        for (int k = 0; k < 16; k++) frame[k] = 12'($urandom);
        load();
        start_pass(2'($urandom));
        repeat (9) tick();
        rst = 1'b0;
        tick();
        pass_active = 1'b0;
        tick();
        rst = 1'b1;
        repeat (20) tick();
        run_pass(2'($urandom));

        repeat (8) begin
            for (int k = 0; k < 16; k++) frame[k] = 12'($urandom);
            load();
            run_pass(2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_conv3x3_engine.md
Name: frame_conv3x3_engine

Overview:
- Parametrised 3x3 neighbourhood filter engine for the frame-buffer path.
- Reads a full frame of packed RGB pixels sequentially from frame RAM over a read port with 1-cycle latency.
- Holds two internal line buffers plus a 3x3 window, applies a runtime-selected mode, and streams results back to RAM one pixel per cycle.
- Started by the control FSM with a start pulse; completion reported by a done pulse.

Parameters:
IMG_W, 640, frame width in pixels (>=3)
IMG_H, 480, frame height in lines (>=3)
CH_W, 4, bits per colour channel; pixel width PIX_W = 3*CH_W, packed {R,G,B}
AW, 19, RAM address width; must satisfy 2^AW >= IMG_W*IMG_H + DST_OFFSET
DST_OFFSET, 0, added to pixel index to form write address (0 = in-place)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset (0 = reset)
start  in  1  begin one frame pass; sampled only in IDLE
mode  in  2  0 PASS, 1 GRAY, 2 SHARPEN, 3 EDGE; latched when start is accepted
busy  out  1  high from start acceptance until done pulse (inclusive)
done  out  1  one-cycle pulse after last write
rd_en  out  1  RAM read enable
rd_addr  out  AW  RAM read address
rd_data  in  PIX_W  RAM read data, valid the cycle after rd_en
wr_en  out  1  RAM write enable
wr_addr  out  AW  RAM write address
wr_data  out  PIX_W  RAM write data

Behaviour:
- Reset (rst=0 at a clock edge): FSM to IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0; counters cleared. Line-buffer contents are don't-care. Reset mid-frame aborts immediately; no further writes and no done.
- States: IDLE -> RUN on start=1. RUN -> FLUSH after the read of index N-1 (N = IMG_W*IMG_H). FLUSH -> DONE after the write of index N-1. DONE -> IDLE after one cycle, with done=1 in that cycle.
- start in any state other than IDLE is ignored; mode changes are ignored after latching.
- Read timing, with C0 the cycle start is accepted:
  - rd_en=1, rd_addr=k in cycle C0+1+k, for k = 0..N-1, consecutive with no gaps.
  - rd_en=0 otherwise.
- Window: pixel o = (x,y) is output once pixel o+IMG_W+1 has arrived. Positions beyond N-1 are fed as zero during FLUSH.
- Neighbours outside the frame (x-1<0, x+1>=IMG_W, y-1<0, y+1>=IMG_H) contribute 0. No wrap from row end to next row start.
- Write timing:
  - wr_en=1, wr_addr=o+DST_OFFSET in cycle C0+IMG_W+4+o, for o = 0..N-1, consecutive.
  - Exactly N writes per pass.
  - done is high in cycle C0+IMG_W+4+N.
- In-place (DST_OFFSET=0) is legal: every address is read before it is written.
- Luma: Y = floor((30*R + 59*G + 11*B)/100), CH_W bits. Intermediate width must hold 100*(2^CH_W-1).
- Modes:
  - PASS: wr_data = centre pixel unchanged.
  - GRAY: wr_data = {Y,Y,Y} of the centre.
  - SHARPEN: v = 9*Yc - sum of in-frame neighbour Y.
  - EDGE: v = 8*Yc - sum of in-frame neighbour Y.
- SHARPEN/EDGE: v is computed signed, with width >= CH_W+5 bits. It is clamped to [0, 2^CH_W-1], and wr_data = {v,v,v}.
- Outputs are registered; wr_data and wr_addr are don't-care when wr_en=0.

Test Plan (IMG_W=4, IMG_H=3, CH_W=4, AW=19, N=12, start accepted at C0):
1. Hold rst=0 with random inputs -> busy=done=rd_en=wr_en=0 and all address/data outputs 0. Release; keep start=0 for 20 cycles -> no rd_en and no wr_en.
2. PASS, RAM[k]=k*12'h111 -> rd_addr 0..11 at C0+1..C0+12; wr_en at C0+8..C0+19 with wr_addr 0..11 and wr_data = RAM[k] (pre-pass values). done=1 only at C0+20; busy low at C0+21.
3. GRAY, all pixels 12'hF00 -> every wr_data = 12'h444 (Y = 450/100 = 4). Same pixel 12'h0F0 -> 12'h888.
4. Uniform frame 12'h777 (Y=7), covering all frame positions:
   - SHARPEN: interior pixels 5 and 6 -> 12'h777; corners (63-21=42) -> 12'hFFF; non-corner border (63-35=28) -> 12'hFFF.
   - EDGE: interior -> 12'h000; corners (56-21=35) -> 12'hFFF.
5. Single bright pixel 12'hFFF at (1,1), rest 0, EDGE -> index 5 = 12'hFFF (8*15=120, clamped); its 8 neighbours -> 12'h000 (negative, clamped); index 3 (no wrap into row 1) -> 12'h000.
6. Pulse start again mid-RUN with mode=0 -> ignored; the pass completes in the original mode with 12 writes. Then assert rst=0 at C0+10 of a new pass -> wr_en=0 from the next cycle and no done. A following start runs a full, correct pass.
